// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage, the fetch queue and decode.
// The queue connects through the slave modport; the fetch/decode side
// (or a testbench) uses the master modport.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 30,
    parameter int IW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Fetch side
    logic          flush;
    logic          in_valid;
    logic [AW-1:0] in_pc;
    logic [IW-1:0] in_inst;
    logic          in_ready;
    logic          fetch_en;

    // Decode side
    logic          out_valid;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_inst;
    logic          out_ready;

    // Status
    logic [CW-1:0] count;
    logic          ovf_err;

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, fetch_en, out_valid, out_pc, out_inst, count, ovf_err
    );

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, fetch_en, out_valid, out_pc, out_inst, count, ovf_err
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a small circular buffer of {pc, inst} pairs that
// decouples instruction memory returns from decode. fetch_en throttles the
// fetch stage one entry early so a memory return already in flight always
// has a slot. A flush (taken jump) empties the queue and discards the next
// cycle's return, which belongs to the wrong path.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 30,
    parameter int IW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] FETCH_MAX  = CW'(DEPTH - 2);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          drop_q;
    logic          ovf_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // A push is never enabled by a same-cycle pop: in_ready looks only at
    // the registered occupancy, which keeps in_ready free of out_ready.
    assign push = bus.in_valid & ~full & ~bus.flush & ~drop_q;
    assign pop  = ~empty & bus.out_ready & ~bus.flush;

    // Pointer, occupancy and drop bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= 1'b1;
        end else begin
            drop_q <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag: a valid return that found the queue full.
    // Returns discarded by drop are wrong-path and do not count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid && full && !drop_q) begin
            ovf_q <= 1'b1;
        end
    end

    // Entry storage; written on push only, never cleared.
    // NOTE: the storage array has no reset -- visibility is governed by
    // count/pointers, so stale entries are never exposed and the array
    // can map to plain RAM or flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: bus.in_pc, inst: bus.in_inst};
        end
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_pc    = empty ? '0 : mem[rd_ptr].pc;
    assign bus.out_inst  = empty ? '0 : mem[rd_ptr].inst;
    assign bus.fetch_en  = ~rst & (count_q <= FETCH_MAX);
    assign bus.count     = count_q;
    assign bus.ovf_err   = ovf_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=4, AW=30, IW=32).
// A table of per-cycle vectors covers in-order push/pop, fill to full with
// overflow, wrap-around under continuous pop and single-cycle flush; short
// hand-written sequences cover a held flush and an asynchronous reset pulse.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 30;
    localparam int IW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          flush;
        logic          in_valid;
        logic [AW-1:0] in_pc;
        logic [IW-1:0] in_inst;
        logic          out_ready;
        logic          e_valid;
        logic [AW-1:0] e_pc;
        logic [IW-1:0] e_inst;
        logic [CW-1:0] e_count;
        logic          e_ready;
        logic          e_fetch_en;
        logic          e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, input logic iv, input logic [AW-1:0] pc,
                       input logic [IW-1:0] inst, input logic ordy,
                       input logic ev, input logic [AW-1:0] epc, input logic [IW-1:0] einst,
                       input int ecnt, input logic erdy, input logic efe, input logic eovf);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.in_pc = pc; v.in_inst = inst; v.out_ready = ordy;
        v.e_valid = ev; v.e_pc = epc; v.e_inst = einst; v.e_count = CW'(ecnt);
        v.e_ready = erdy; v.e_fetch_en = efe; v.e_ovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [AW-1:0] pc,
                         input logic [IW-1:0] inst, input logic ordy);
        bus.flush = fl; bus.in_valid = iv; bus.in_pc = pc; bus.in_inst = inst; bus.out_ready = ordy;
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [AW-1:0] epc,
                             input logic [IW-1:0] einst, input int ecnt, input logic erdy,
                             input logic efe, input logic eovf);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
        check({tag, ".out_pc"},    64'(bus.out_pc),    64'(epc));
        check({tag, ".out_inst"},  64'(bus.out_inst),  64'(einst));
        check({tag, ".count"},     64'(bus.count),     64'(ecnt));
        check({tag, ".in_ready"},  64'(bus.in_ready),  64'(erdy));
        check({tag, ".fetch_en"},  64'(bus.fetch_en),  64'(efe));
        check({tag, ".ovf_err"},   64'(bus.ovf_err),   64'(eovf));
    endtask

    initial begin
        // ---------------- vector table ----------------
        //   fl iv pc     inst           ordy | ev epc    einst         cnt rdy fe ovf
        // Two pushes held, then popped in order
        add(0, 1, 30'h0,  32'hA,          0,   1, 30'h0,  32'hA,          1, 1, 1, 0);
        add(0, 1, 30'h1,  32'hB,          0,   1, 30'h0,  32'hA,          2, 1, 1, 0);
        add(0, 0, 30'h0,  32'h0,          1,   1, 30'h1,  32'hB,          1, 1, 1, 0);
        add(0, 0, 30'h0,  32'h0,          1,   0, 30'h0,  32'h0,          0, 1, 1, 0);
        // Fill to full, overflow, pop does not enable a same-cycle push
        add(0, 1, 30'h10, 32'h0000_1010,  0,   1, 30'h10, 32'h0000_1010,  1, 1, 1, 0);
        add(0, 1, 30'h11, 32'h0000_1011,  0,   1, 30'h10, 32'h0000_1010,  2, 1, 1, 0);
        add(0, 1, 30'h12, 32'h0000_1012,  0,   1, 30'h10, 32'h0000_1010,  3, 1, 0, 0);
        add(0, 1, 30'h13, 32'h0000_1013,  0,   1, 30'h10, 32'h0000_1010,  4, 0, 0, 0);
        add(0, 1, 30'h14, 32'h0000_1014,  0,   1, 30'h10, 32'h0000_1010,  4, 0, 0, 1);
        add(0, 1, 30'h15, 32'h0000_1015,  1,   1, 30'h11, 32'h0000_1011,  3, 1, 0, 1);
        add(0, 0, 30'h0,  32'h0,          1,   1, 30'h12, 32'h0000_1012,  2, 1, 1, 1);
        add(0, 0, 30'h0,  32'h0,          1,   1, 30'h13, 32'h0000_1013,  1, 1, 1, 1);
        add(0, 0, 30'h0,  32'h0,          1,   0, 30'h0,  32'h0,          0, 1, 1, 1);
        // Count 2, then push+pop every cycle: pointers wrap, order kept
        add(0, 1, 30'h20, 32'h0000_2020,  0,   1, 30'h20, 32'h0000_2020,  1, 1, 1, 1);
        add(0, 1, 30'h21, 32'h0000_2021,  0,   1, 30'h20, 32'h0000_2020,  2, 1, 1, 1);
        add(0, 1, 30'h22, 32'h0000_2022,  1,   1, 30'h21, 32'h0000_2021,  2, 1, 1, 1);
        add(0, 1, 30'h23, 32'h0000_2023,  1,   1, 30'h22, 32'h0000_2022,  2, 1, 1, 1);
        add(0, 1, 30'h24, 32'h0000_2024,  1,   1, 30'h23, 32'h0000_2023,  2, 1, 1, 1);
        add(0, 1, 30'h25, 32'h0000_2025,  1,   1, 30'h24, 32'h0000_2024,  2, 1, 1, 1);
        add(0, 0, 30'h0,  32'h0,          1,   1, 30'h25, 32'h0000_2025,  1, 1, 1, 1);
        add(0, 0, 30'h0,  32'h0,          1,   0, 30'h0,  32'h0,          0, 1, 1, 1);
        // Count 3, single-cycle flush with in_valid, next return dropped
        add(0, 1, 30'h30, 32'h0000_3030,  0,   1, 30'h30, 32'h0000_3030,  1, 1, 1, 1);
        add(0, 1, 30'h31, 32'h0000_3031,  0,   1, 30'h30, 32'h0000_3030,  2, 1, 1, 1);
        add(0, 1, 30'h32, 32'h0000_3032,  0,   1, 30'h30, 32'h0000_3030,  3, 1, 0, 1);
        add(1, 1, 30'h33, 32'h0000_3033,  1,   0, 30'h0,  32'h0,          0, 1, 1, 1);
        add(0, 1, 30'h7,  32'h0000_0777,  0,   0, 30'h0,  32'h0,          0, 1, 1, 1);
        add(0, 1, 30'h20, 32'h0000_5A20,  0,   1, 30'h20, 32'h0000_5A20,  1, 1, 1, 1);
        add(0, 0, 30'h0,  32'h0,          1,   0, 30'h0,  32'h0,          0, 1, 1, 1);

        // ---------------- reset state ----------------
        drive(0, 0, '0, '0, 0);
        #2;
        check_all("reset", 0, '0, '0, 0, 1, 0, 0);
        step();
        step();
        #3 rst = 1'b0;
        #1;
        check("release.fetch_en", 64'(bus.fetch_en), 64'(1));

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_pc, vecs[i].in_inst, vecs[i].out_ready);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst,
                      int'(vecs[i].e_count), vecs[i].e_ready, vecs[i].e_fetch_en, vecs[i].e_ovf);
        end

        // ---------------- flush held for three cycles ----------------
        drive(0, 1, 30'h60, 32'h6060, 0); step();
        drive(0, 1, 30'h61, 32'h6061, 0); step();
        check("hold.pre_count", 64'(bus.count), 64'(2));
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 30'(32'h70 + k), 32'h7070, 1);
            step();
            check($sformatf("hold.flush%0d.count", k), 64'(bus.count), 64'(0));
            check($sformatf("hold.flush%0d.valid", k), 64'(bus.out_valid), 64'(0));
        end
        drive(0, 1, 30'h40, 32'h4040, 0); step();
        check("hold.dropped.count", 64'(bus.count), 64'(0));
        drive(0, 1, 30'h41, 32'h4041, 0); step();
        check("hold.push.count", 64'(bus.count), 64'(1));
        check("hold.push.pc",    64'(bus.out_pc), 64'(30'h41));
        drive(0, 0, '0, '0, 1); step();
        check("hold.drain.count", 64'(bus.count), 64'(0));

        // ---------------- async reset mid-operation ----------------
        drive(0, 1, 30'h50, 32'h5050, 0); step();
        drive(0, 1, 30'h51, 32'h5051, 0); step();
        drive(0, 1, 30'h52, 32'h5052, 0); step();
        check("arst.pre_count", 64'(bus.count), 64'(3));
        drive(0, 1, 30'h53, 32'h5053, 0);
        #2 rst = 1'b1;
        #1;
        check_all("arst", 0, '0, '0, 0, 1, 0, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst.release.fetch_en", 64'(bus.fetch_en), 64'(1));
        check("arst.release.count",    64'(bus.count),    64'(0));
        drive(0, 1, 30'h58, 32'h5858, 0); step();
        check_all("arst.push", 1, 30'h58, 32'h5858, 1, 1, 1, 0);
        drive(0, 0, '0, '0, 1); step();
        check("arst.drain.valid", 64'(bus.out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
